// File: rtl/pwm_dac_if.sv
// Sample/PWM bus between the sine generator side and the PWM DAC.
//
// Handshake: there is no valid/ready pair. The DAC pulses sample_req high for
// exactly one clk at every PWM period boundary. The producer loads its next
// sample on that same edge and holds sample_in steady. The DAC captures
// sample_in only on the following boundary, so sample_in is don't-care
// everywhere else. en is a level enable driven by the master.
interface pwm_dac_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] sample_in;
  logic             sample_req;
  logic             pwm_out;
  logic [WIDTH-1:0] duty_q;

  // Producer / controller side.
  modport master (
    output en,
    output sample_in,
    input  sample_req,
    input  pwm_out,
    input  duty_q
  );

  // PWM DAC side.
  modport slave (
    input  en,
    input  sample_in,
    output sample_req,
    output pwm_out,
    output duty_q
  );
endinterface

// File: rtl/pwm_dac.sv
// PWM DAC: turns an unsigned offset-binary sample into a fixed-period PWM
// waveform and paces the upstream generator with a once-per-period request.
// Duty is only updated at the period boundary, so a period never glitches.
module pwm_dac #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic     clk,
  input  logic     rst,
  pwm_dac_if.slave bus
);

  // Prescaler width; at least one bit so PRESCALE=1 still has a legal vector.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  logic [PW-1:0]    r_pre_cnt;
  logic [WIDTH-1:0] r_pwm_cnt;
  logic [WIDTH-1:0] r_duty_q;
  logic             r_pwm_out;
  logic             r_sample_req;

  logic             w_tick;
  logic             w_wrap;
  logic [PW-1:0]    w_pre_cnt_next;
  logic [WIDTH-1:0] w_pwm_cnt_next;
  logic [WIDTH-1:0] w_duty_next;
  logic             w_pwm_next;

  // Next-state: prescaler, period counter, boundary latch and PWM compare.
  // The compare uses the next count and next duty so the registered output
  // lines up with the registered counter value.
  always_comb begin
    w_tick         = bus.en && (r_pre_cnt == PRE_LAST);
    w_wrap         = w_tick && (r_pwm_cnt == CNT_LAST);
    w_pre_cnt_next = r_pre_cnt;
    w_pwm_cnt_next = r_pwm_cnt;
    w_duty_next    = r_duty_q;
    if (bus.en) begin
      w_pre_cnt_next = w_tick ? '0 : r_pre_cnt + 1'b1;
    end
    if (w_tick) begin
      w_pwm_cnt_next = r_pwm_cnt + 1'b1;
    end
    if (w_wrap) begin
      w_duty_next = bus.sample_in;
    end
    w_pwm_next = bus.en && (w_pwm_cnt_next < w_duty_next);
  end

  // State registers; en=0 holds counters and duty, and forces outputs low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt    <= '0;
      r_pwm_cnt    <= '0;
      r_duty_q     <= '0;
      r_pwm_out    <= 1'b0;
      r_sample_req <= 1'b0;
    end else begin
      r_pre_cnt    <= w_pre_cnt_next;
      r_pwm_cnt    <= w_pwm_cnt_next;
      r_duty_q     <= w_duty_next;
      r_pwm_out    <= w_pwm_next;
      r_sample_req <= w_wrap;
    end
  end

  assign bus.pwm_out    = r_pwm_out;
  assign bus.sample_req = r_sample_req;
  assign bus.duty_q     = r_duty_q;

endmodule
